// File: rtl/comperator_axi_ip_v1_0_block_writer.sv
// comperator_axi_ip_v1_0_block_writer
// AXI4-Stream master that serialises one parallel block of 24-bit pixels
// into consecutive beats. The first pixel sits in slice len-1 of the block,
// the last in slice 0, so the block is left-aligned into a shift register
// and the top slice is always the current beat.
// Optional build macro: COMPERATOR_BLOCK_WRITER_BACKTOBACK_EN
//   defined   -> a go on the final handshake loads the next block with no bubble
//   undefined -> at least one DONE cycle separates consecutive blocks
module comperator_axi_ip_v1_0_block_writer #(
  parameter int BLOCK_SIZE = 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       go,
  input  logic [BLOCK_SIZE*24-1:0]   block,
  input  logic [15:0]                len,
  input  logic                       sof,
  input  logic                       eol,
  output logic                       done,
  output logic                       busy,
  output logic [23:0]                m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tuser,
  output logic                       m_axis_tlast
);

  localparam int DATA_WIDTH  = 24;
  localparam int BLOCK_WIDTH = BLOCK_SIZE * DATA_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]             state;
  logic [BLOCK_WIDTH-1:0] shreg;
  logic [15:0]            remaining;
  logic                   eol_l;

  logic [15:0]            lenc;
  logic [BLOCK_WIDTH-1:0] load_val;
  logic                   hs;
  logic                   go_ok;

  // Clamp the requested length and left-align the block so pixel 0 is on top
  always_comb begin
    lenc     = (len > 16'(BLOCK_SIZE)) ? 16'(BLOCK_SIZE) : len;
    load_val = block << ((BLOCK_SIZE - int'(lenc)) * DATA_WIDTH);
  end

  // Handshake and go-acceptance decode
  always_comb begin
    hs    = m_axis_tvalid && m_axis_tready;
    go_ok = go && ((state == IDLE) || (state == DONE));
`ifdef COMPERATOR_BLOCK_WRITER_BACKTOBACK_EN
    if (go && (state == SEND) && hs && (remaining == 16'd1))
      go_ok = 1'b1;
`endif
  end

  // The current beat is always the top slice of the shift register
  assign m_axis_tdata = shreg[BLOCK_WIDTH-1 -: DATA_WIDTH];

  // Control FSM with registered stream outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      shreg         <= '0;
      remaining     <= '0;
      eol_l         <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tuser  <= 1'b0;
      m_axis_tlast  <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else if (go_ok) begin
      shreg     <= load_val;
      remaining <= lenc;
      eol_l     <= eol;
      if (lenc != 16'd0) begin
        state         <= SEND;
        m_axis_tvalid <= 1'b1;
        m_axis_tuser  <= sof;
        m_axis_tlast  <= eol && (lenc == 16'd1);
        busy          <= 1'b1;
        // a load straight out of SEND is a back-to-back block: done pulses once
        done          <= (state == SEND);
      end else begin
        state         <= DONE;
        m_axis_tvalid <= 1'b0;
        m_axis_tuser  <= 1'b0;
        m_axis_tlast  <= 1'b0;
        busy          <= 1'b0;
        done          <= 1'b1;
      end
    end else begin
      case (state)
        SEND: begin
          done <= 1'b0;
          if (hs) begin
            if (remaining == 16'd1) begin
              state         <= DONE;
              m_axis_tvalid <= 1'b0;
              m_axis_tuser  <= 1'b0;
              m_axis_tlast  <= 1'b0;
              busy          <= 1'b0;
              done          <= 1'b1;
            end else begin
              shreg         <= shreg << DATA_WIDTH;
              remaining     <= remaining - 16'd1;
              m_axis_tuser  <= 1'b0;
              m_axis_tlast  <= eol_l && (remaining == 16'd2);
            end
          end
        end
        IDLE, DONE: ;
        default: begin
          state         <= IDLE;
          m_axis_tvalid <= 1'b0;
          busy          <= 1'b0;
          done          <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_comperator_axi_ip_v1_0_block_writer.sv
// Scoreboard bench for comperator_axi_ip_v1_0_block_writer: stimulus pushes
// expected beats, a negedge monitor pops and compares on each handshake and
// checks stream stability during stalls.
module tb_comperator_axi_ip_v1_0_block_writer;

  localparam int BS = 8;

  typedef struct packed {
    logic [23:0] d;
    logic        u;
    logic        l;
  } beat_t;

  logic              aclk;
  logic              aresetn;
  logic              go;
  logic [BS*24-1:0]  block;
  logic [15:0]       len;
  logic              sof;
  logic              eol;
  logic              done;
  logic              busy;
  logic [23:0]       tdata;
  logic              tvalid;
  logic              tready;
  logic              tuser;
  logic              tlast;

  comperator_axi_ip_v1_0_block_writer #(.BLOCK_SIZE(BS)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .go            (go),
    .block         (block),
    .len           (len),
    .sof           (sof),
    .eol           (eol),
    .done          (done),
    .busy          (busy),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  beat_t       q[$];
  int          checks = 0;
  int          failures = 0;
  int          pops = 0;
  logic [23:0] pix [BS];
  logic        bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // tready generator: 1,0,0,1 repeating under backpressure, else held high
  initial begin
    int k;
    k = 0;
    tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (bp) begin
        case (k % 4)
          0, 3:    tready = 1'b1;
          default: tready = 1'b0;
        endcase
        k++;
      end else begin
        tready = 1'b1;
      end
    end
  end

  // Monitor: compare each handshake against the scoreboard, check stall stability
  initial begin
    logic  stalled;
    beat_t snap;
    beat_t e;
    stalled = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          checks++;
          if (!tvalid || ({tdata, tuser, tlast} !== snap)) begin
            failures++;
            $display("FAIL stall_hold actual=v%0b %h/%0b/%0b required=v1 %h/%0b/%0b",
                     tvalid, tdata, tuser, tlast, snap.d, snap.u, snap.l);
          end
        end
        if (tvalid && tready) begin
          checks++;
          if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", tdata);
          end else begin
            e = q.pop_front();
            if ({tdata, tuser, tlast} !== e) begin
              failures++;
              $display("FAIL beat actual=%h/u%0b/l%0b required=%h/u%0b/l%0b",
                       tdata, tuser, tlast, e.d, e.u, e.l);
            end
          end
          pops++;
          stalled = 1'b0;
        end else if (tvalid) begin
          stalled = 1'b1;
          snap    = {tdata, tuser, tlast};
        end else begin
          stalled = 1'b0;
        end
      end
    end
  end

  // Place pix[i] in slice nc-1-i and queue the expected beats
  task automatic setup(input logic [15:0] l, input logic s, input logic e);
    int nc;
    beat_t b;
    nc = (l > 16'(BS)) ? BS : int'(l);
    block = '0;
    for (int i = 0; i < nc; i++) block[(nc-1-i)*24 +: 24] = pix[i];
    len = l;
    sof = s;
    eol = e;
    for (int i = 0; i < nc; i++) begin
      b.d = pix[i];
      b.u = s && (i == 0);
      b.l = e && (i == nc - 1);
      q.push_back(b);
    end
  endtask

  task automatic launch(input logic [15:0] l, input logic s, input logic e);
    @(posedge aclk);
    #1;
    setup(l, s, e);
    go = 1'b1;
    @(posedge aclk);
    #1;
    go = 1'b0;
    block = {BS{24'hDEAD00}};
    len = 16'hFFFF;
  endtask

  task automatic wait_done(input string name, input int exp_n);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      #1;
      n++;
    end while (!done && n < 200);
    chk({name, "_done"}, done, 1);
    if (exp_n > 0) chk({name, "_latency"}, n, exp_n);
    chk({name, "_drained"}, q.size(), 0);
  endtask

  task automatic wait_pops(input int target);
    for (int i = 0; i < 200 && pops < target; i++) begin
      @(negedge aclk);
      #1;
    end
    chk("pop_count", pops, target);
  endtask

  initial begin
    int base;
    aresetn = 1'b1;
    go = 1'b0;
    block = '0;
    len = '0;
    sof = 1'b0;
    eol = 1'b0;
    #2 aresetn = 1'b0;
    #1;
    chk("rst_tvalid", tvalid, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser_tlast", {tuser, tlast}, 0);
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Full block, no backpressure
    for (int i = 0; i < BS; i++) pix[i] = 24'(i + 1);
    launch(16'd8, 1'b1, 1'b1);
    wait_done("full", 9);
    chk("full_busy_low", busy, 0);

    // Partial block
    pix[0] = 24'hAA0000; pix[1] = 24'h00BB00; pix[2] = 24'h0000CC;
    launch(16'd3, 1'b0, 1'b1);
    wait_done("partial", 4);

    // Backpressure
    for (int i = 0; i < BS; i++) pix[i] = 24'h100010 + 24'(i);
    bp = 1'b1;
    launch(16'd8, 1'b1, 1'b1);
    wait_done("bp", 0);
    bp = 1'b0;

    // Zero length: no beats, done after one cycle
    launch(16'd0, 1'b1, 1'b1);
    wait_done("len0", 1);
    chk("len0_tvalid", tvalid, 0);

    // Oversized length clamps to the block size
    for (int i = 0; i < BS; i++) pix[i] = 24'h200020 + 24'(i);
    launch(16'd20, 1'b1, 1'b0);
    wait_done("len20", 9);

    // Reset after beat 4
    for (int i = 0; i < BS; i++) pix[i] = 24'h300030 + 24'(i);
    base = pops;
    launch(16'd8, 1'b1, 1'b1);
    wait_pops(base + 4);
    @(posedge aclk);
    #1 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", tvalid, 0);
    chk("midrst_busy", busy, 0);
    q.delete();
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    #1;
    chk("postrst_done", done, 0);
    chk("postrst_tvalid", tvalid, 0);
    for (int i = 0; i < BS; i++) pix[i] = 24'h400040 + 24'(i);
    launch(16'd8, 1'b1, 1'b1);
    wait_done("postrst", 9);

    // Back-to-back blocks with go held high
    @(posedge aclk);
    #1;
    for (int i = 0; i < BS; i++) pix[i] = 24'h500050 + 24'(i);
    setup(16'd8, 1'b1, 1'b0);
    go = 1'b1;
    base = pops;
    @(posedge aclk);
    #1;
    for (int i = 0; i < BS; i++) pix[i] = 24'h600060 + 24'(i);
    setup(16'd8, 1'b0, 1'b1);
    wait_pops(base + 8);
    @(negedge aclk);
    #1;
`ifdef COMPERATOR_BLOCK_WRITER_BACKTOBACK_EN
    chk("b2b_no_bubble", tvalid, 1);
    chk("b2b_done_pulse", done, 1);
    chk("b2b_busy", busy, 1);
    go = 1'b0;
    @(negedge aclk);
    #1;
    chk("b2b_done_fell", done, 0);
`else
    chk("b2b_bubble", tvalid, 0);
    chk("b2b_done", done, 1);
    @(negedge aclk);
    #1;
    chk("b2b_resume", tvalid, 1);
    chk("b2b_done_fell", done, 0);
    go = 1'b0;
`endif
    wait_done("b2b", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
